// File: rtl/pong_engine.sv
// Game-state engine for the 8x8 pong matrix: ball, paddles, scores and match flow.
// Define PONG_SPEEDUP_EN to make the ball speed up on each paddle hit.
module pong_engine #(
  parameter int unsigned TICK_DIV    = 4000000,
  parameter int unsigned PADDLE_DIV  = 2000000,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned WIN_SCORE   = 5,
  parameter int unsigned POINT_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       btn_top_l,
  input  logic       btn_top_r,
  input  logic       btn_down_l,
  input  logic       btn_down_r,
  output logic [2:0] x_pos,
  output logic [2:0] y_pos,
  output logic [2:0] player_top,
  output logic [2:0] player_down,
  output logic [3:0] score_top,
  output logic [3:0] score_down,
  output logic       game_over
);

  localparam int unsigned PT_W = (POINT_TICKS < 2) ? 1 : $clog2(POINT_TICKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVE,
    S_PLAY,
    S_POINT,
    S_OVER
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] ball_cnt, ball_cnt_nxt;
  logic [CNT_W-1:0] pad_cnt, pad_cnt_nxt;
  logic [CNT_W-1:0] ball_wrap;
  logic [PT_W-1:0]  pt_cnt, pt_cnt_nxt;
  logic [2:0]       x_nxt, y_nxt, pt_nxt, pd_nxt;
  logic [3:0]       st_nxt, sd_nxt;
  logic             go_nxt;
  // Direction bits: 1 means +1 (right / down), 0 means -1.
  logic             dx, dx_nxt, dy, dy_nxt;
  logic             top_scored, top_scored_nxt;
  logic             active, ball_tick, pad_tick;
  logic             dx_eff, pad_hit;
  logic [2:0]       nx;

`ifdef PONG_SPEEDUP_EN
  logic [1:0]       level, level_nxt;
  logic [CNT_W-1:0] ball_div;

  always_comb begin
    ball_div  = CNT_W'(TICK_DIV) >> level;
    ball_wrap = (ball_div > CNT_W'(1)) ? ball_div - CNT_W'(1) : CNT_W'(1);
  end
`else
  assign ball_wrap = CNT_W'(TICK_DIV - 1);
`endif

  assign active    = (state == S_SERVE) || (state == S_PLAY) || (state == S_POINT);
  assign ball_tick = active && (ball_cnt == ball_wrap);
  assign pad_tick  = active && (pad_cnt == CNT_W'(PADDLE_DIV - 1));

  // Wall bounce flips dx before the step, so a ball in a corner column reverses in place.
  assign dx_eff = ((x_pos == 3'd0) && !dx) || ((x_pos == 3'd7) && dx) ? ~dx : dx;
  assign nx     = dx_eff ? x_pos + 3'd1 : x_pos - 3'd1;

  always_comb begin
    state_nxt      = state;
    ball_cnt_nxt   = '0;
    pad_cnt_nxt    = '0;
    pt_cnt_nxt     = pt_cnt;
    x_nxt          = x_pos;
    y_nxt          = y_pos;
    pt_nxt         = player_top;
    pd_nxt         = player_down;
    st_nxt         = score_top;
    sd_nxt         = score_down;
    go_nxt         = game_over;
    dx_nxt         = dx;
    dy_nxt         = dy;
    top_scored_nxt = top_scored;
    pad_hit        = 1'b0;
`ifdef PONG_SPEEDUP_EN
    level_nxt      = level;
`endif

    if (active) begin
      ball_cnt_nxt = ball_tick ? '0 : ball_cnt + CNT_W'(1);
      pad_cnt_nxt  = pad_tick  ? '0 : pad_cnt  + CNT_W'(1);
    end

    if (pad_tick) begin
      if (btn_top_l && !btn_top_r && (player_top != 3'd0))
        pt_nxt = player_top - 3'd1;
      else if (btn_top_r && !btn_top_l && (player_top != 3'd6))
        pt_nxt = player_top + 3'd1;
      if (btn_down_l && !btn_down_r && (player_down != 3'd0))
        pd_nxt = player_down - 3'd1;
      else if (btn_down_r && !btn_down_l && (player_down != 3'd6))
        pd_nxt = player_down + 3'd1;
    end

    case (state)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_nxt = S_SERVE;
          st_nxt    = '0;
          sd_nxt    = '0;
          go_nxt    = 1'b0;
          dx_nxt    = 1'b1;
          dy_nxt    = 1'b1;
          x_nxt     = 3'd3;
          y_nxt     = 3'd3;
        end
      end

      S_SERVE: begin
        x_nxt = 3'd3;
        y_nxt = 3'd3;
`ifdef PONG_SPEEDUP_EN
        level_nxt = '0;
`endif
        if (ball_tick)
          state_nxt = S_PLAY;
      end

      S_PLAY: begin
        if (ball_tick) begin
          dx_nxt = dx_eff;
          x_nxt  = nx;
          // Hit tests read the paddle registers, i.e. the value before this edge's move.
          if ((y_pos == 3'd6) && dy) begin
            if ((nx == player_down) || (nx == player_down + 3'd1)) begin
              dy_nxt  = 1'b0;
              y_nxt   = 3'd5;
              pad_hit = 1'b1;
            end else begin
              y_nxt          = 3'd7;
              st_nxt         = score_top + 4'd1;
              top_scored_nxt = 1'b1;
              pt_cnt_nxt     = '0;
              state_nxt      = S_POINT;
            end
          end else if ((y_pos == 3'd1) && !dy) begin
            if ((nx == player_top) || (nx == player_top + 3'd1)) begin
              dy_nxt  = 1'b1;
              y_nxt   = 3'd2;
              pad_hit = 1'b1;
            end else begin
              y_nxt          = 3'd0;
              sd_nxt         = score_down + 4'd1;
              top_scored_nxt = 1'b0;
              pt_cnt_nxt     = '0;
              state_nxt      = S_POINT;
            end
          end else begin
            y_nxt = dy ? y_pos + 3'd1 : y_pos - 3'd1;
          end
        end
      end

      S_POINT: begin
        if (ball_tick) begin
          if (pt_cnt == PT_W'(POINT_TICKS - 1)) begin
            pt_cnt_nxt = '0;
            if ((top_scored ? score_top : score_down) == 4'(WIN_SCORE)) begin
              state_nxt = S_OVER;
              go_nxt    = 1'b1;
            end else begin
              // Serve heads toward whoever lost the point.
              state_nxt = S_SERVE;
              x_nxt     = 3'd3;
              y_nxt     = 3'd3;
              dx_nxt    = 1'b1;
              dy_nxt    = top_scored;
            end
          end else begin
            pt_cnt_nxt = pt_cnt + PT_W'(1);
          end
        end
      end

      default: state_nxt = S_IDLE;
    endcase

`ifdef PONG_SPEEDUP_EN
    if (pad_hit && (level != 2'd3))
      level_nxt = level + 2'd1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ball_cnt    <= '0;
      pad_cnt     <= '0;
      pt_cnt      <= '0;
      x_pos       <= 3'd3;
      y_pos       <= 3'd3;
      player_top  <= 3'd3;
      player_down <= 3'd3;
      score_top   <= '0;
      score_down  <= '0;
      game_over   <= 1'b0;
      dx          <= 1'b1;
      dy          <= 1'b1;
      top_scored  <= 1'b0;
`ifdef PONG_SPEEDUP_EN
      level       <= '0;
`endif
    end else begin
      state       <= state_nxt;
      ball_cnt    <= ball_cnt_nxt;
      pad_cnt     <= pad_cnt_nxt;
      pt_cnt      <= pt_cnt_nxt;
      x_pos       <= x_nxt;
      y_pos       <= y_nxt;
      player_top  <= pt_nxt;
      player_down <= pd_nxt;
      score_top   <= st_nxt;
      score_down  <= sd_nxt;
      game_over   <= go_nxt;
      dx          <= dx_nxt;
      dy          <= dy_nxt;
      top_scored  <= top_scored_nxt;
`ifdef PONG_SPEEDUP_EN
      level       <= level_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_pong_engine.sv
// Self-checking bench for pong_engine: directed table, hand sequences, random vs. reference model.
module tb_pong_engine;

  localparam int TD = 4;
  localparam int PD = 2;
  localparam int WS = 2;
  localparam int PT = 4;

  localparam int MS_IDLE  = 0;
  localparam int MS_SERVE = 1;
  localparam int MS_PLAY  = 2;
  localparam int MS_POINT = 3;
  localparam int MS_OVER  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       btn_top_l = 1'b0, btn_top_r = 1'b0, btn_down_l = 1'b0, btn_down_r = 1'b0;
  logic [2:0] x_pos, y_pos, player_top, player_down;
  logic [3:0] score_top, score_down;
  logic       game_over;

  int n_tests = 0;
  int n_fail  = 0;

  pong_engine #(
    .TICK_DIV   (TD),
    .PADDLE_DIV (PD),
    .CNT_W      (4),
    .WIN_SCORE  (WS),
    .POINT_TICKS(PT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .btn_top_l  (btn_top_l),
    .btn_top_r  (btn_top_r),
    .btn_down_l (btn_down_l),
    .btn_down_r (btn_down_r),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .player_top (player_top),
    .player_down(player_down),
    .score_top  (score_top),
    .score_down (score_down),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers, one call per rising edge.
  int m_state, m_x, m_y, m_dx, m_dy, m_pt, m_pd, m_st, m_sd, m_go;
  int m_bc, m_pc, m_pk, m_topwon;

  task automatic model_reset();
    m_state = MS_IDLE; m_x = 3; m_y = 3; m_dx = 1; m_dy = 1;
    m_pt = 3; m_pd = 3; m_st = 0; m_sd = 0; m_go = 0;
    m_bc = 0; m_pc = 0; m_pk = 0; m_topwon = 0;
  endtask

  task automatic new_match();
    m_st = 0; m_sd = 0; m_dx = 1; m_dy = 1; m_go = 0;
    m_x = 3; m_y = 3; m_state = MS_SERVE;
  endtask

  task automatic model_step(input bit s, input bit tl, input bit tr, input bit dl, input bit dr);
    bit act, bt, pk;
    int nx;
    act = (m_state == MS_SERVE) || (m_state == MS_PLAY) || (m_state == MS_POINT);
    bt  = act && ((m_bc % TD) == TD - 1);
    pk  = act && ((m_pc % PD) == PD - 1);
    m_bc = act ? m_bc + 1 : 0;
    m_pc = act ? m_pc + 1 : 0;
    case (m_state)
      MS_IDLE, MS_OVER: if (s) new_match();
      MS_SERVE: begin
        m_x = 3; m_y = 3;
        if (bt) m_state = MS_PLAY;
      end
      MS_PLAY: if (bt) begin
        if ((m_x == 0 && m_dx < 0) || (m_x == 7 && m_dx > 0)) m_dx = -m_dx;
        nx = m_x + m_dx;
        if (m_y == 6 && m_dy > 0) begin
          if (nx == m_pd || nx == m_pd + 1) begin m_dy = -1; m_y = 5; end
          else begin m_y = 7; m_st++; m_topwon = 1; m_pk = 0; m_state = MS_POINT; end
        end else if (m_y == 1 && m_dy < 0) begin
          if (nx == m_pt || nx == m_pt + 1) begin m_dy = 1; m_y = 2; end
          else begin m_y = 0; m_sd++; m_topwon = 0; m_pk = 0; m_state = MS_POINT; end
        end else begin
          m_y = m_y + m_dy;
        end
        m_x = nx;
      end
      MS_POINT: if (bt) begin
        m_pk++;
        if (m_pk == PT) begin
          m_pk = 0;
          if ((m_topwon != 0 ? m_st : m_sd) == WS) begin
            m_state = MS_OVER; m_go = 1;
          end else begin
            m_state = MS_SERVE; m_x = 3; m_y = 3; m_dx = 1;
            m_dy = (m_topwon != 0) ? 1 : -1;
          end
        end
      end
      default: ;
    endcase
    if (pk) begin
      if (tl && !tr && m_pt > 0) m_pt--;
      else if (tr && !tl && m_pt < 6) m_pt++;
      if (dl && !dr && m_pd > 0) m_pd--;
      else if (dr && !dl && m_pd < 6) m_pd++;
    end
  endtask

  function automatic logic [20:0] pack(int x, int y, int pt, int pd, int st, int sd, int go);
    return {3'(x), 3'(y), 3'(pt), 3'(pd), 4'(st), 4'(sd), 1'(go)};
  endfunction

  task automatic check(input string name, input logic [20:0] exp);
    logic [20:0] act;
    act = {x_pos, y_pos, player_top, player_down, score_top, score_down, game_over};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got x=%0d y=%0d pt=%0d pd=%0d st=%0d sd=%0d go=%0d, expected x=%0d y=%0d pt=%0d pd=%0d st=%0d sd=%0d go=%0d",
               name, act[20:18], act[17:15], act[14:12], act[11:9], act[8:5], act[4:1], act[0],
               exp[20:18], exp[17:15], exp[14:12], exp[11:9], exp[8:5], exp[4:1], exp[0]);
    end
  endtask

  task automatic check_model(input string name);
    check(name, pack(m_x, m_y, m_pt, m_pd, m_st, m_sd, m_go));
  endtask

  // Called 1 time unit after a rising edge; leaves the bench at the same phase.
  task automatic step(input bit s, input bit tl, input bit tr, input bit dl, input bit dr);
    start = s; btn_top_l = tl; btn_top_r = tr; btn_down_l = dl; btn_down_r = dr;
    @(posedge clk);
    model_step(s, tl, tr, dl, dr);
    #1;
  endtask

  task automatic do_reset(input string name);
    start = 1'b0; btn_top_l = 1'b0; btn_top_r = 1'b0; btn_down_l = 1'b0; btn_down_r = 1'b0;
    rst_n = 1'b0;
    #2;
    check(name, pack(3, 3, 3, 3, 0, 0, 0));
    #2;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    model_step(0, 0, 0, 0, 0);
    #1;
  endtask

  typedef struct {
    bit          s;
    int          n;
    logic [20:0] exp;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1, 1,  pack(3, 3, 3, 3, 0, 0, 0)};
    tbl[1]  = '{0, 4,  pack(3, 3, 3, 3, 0, 0, 0)};
    tbl[2]  = '{0, 4,  pack(4, 4, 3, 3, 0, 0, 0)};
    tbl[3]  = '{0, 4,  pack(5, 5, 3, 3, 0, 0, 0)};
    tbl[4]  = '{0, 4,  pack(6, 6, 3, 3, 0, 0, 0)};
    tbl[5]  = '{0, 4,  pack(7, 7, 3, 3, 1, 0, 0)};
    tbl[6]  = '{0, 12, pack(7, 7, 3, 3, 1, 0, 0)};
    tbl[7]  = '{0, 4,  pack(3, 3, 3, 3, 1, 0, 0)};
    tbl[8]  = '{0, 4,  pack(3, 3, 3, 3, 1, 0, 0)};
    tbl[9]  = '{0, 16, pack(7, 7, 3, 3, 2, 0, 0)};
    tbl[10] = '{0, 16, pack(7, 7, 3, 3, 2, 0, 1)};
    tbl[11] = '{0, 20, pack(7, 7, 3, 3, 2, 0, 1)};
    tbl[12] = '{1, 1,  pack(3, 3, 3, 3, 0, 0, 0)};

    #1;
    do_reset("reset_initial");

    // Serve, down-edge misses, point delay, match end and restart.
    for (int i = 0; i < 13; i++) begin
      repeat (tbl[i].n) step(tbl[i].s, 0, 0, 0, 0);
      check($sformatf("table_%0d", i), tbl[i].exp);
    end

    // Down paddle moved under the ball, right-wall bounce, top miss, serve toward loser.
    do_reset("reset_seq_a");
    step(1, 0, 0, 0, 0);
    repeat (6)  step(0, 0, 0, 0, 1);
    repeat (14) step(0, 0, 0, 0, 0);
    check("down_hit", pack(7, 5, 3, 6, 0, 0, 0));
    repeat (4)  step(0, 0, 0, 0, 0);
    check("right_wall", pack(6, 4, 3, 6, 0, 0, 0));
    repeat (12) step(0, 0, 0, 0, 0);
    check("approach_top", pack(3, 1, 3, 6, 0, 0, 0));
    repeat (4)  step(0, 0, 0, 0, 0);
    check("top_miss", pack(2, 0, 3, 6, 0, 1, 0));
    repeat (16) step(0, 0, 0, 0, 0);
    check("reserve", pack(3, 3, 3, 6, 0, 1, 0));
    repeat (8)  step(0, 0, 0, 0, 0);
    check("serve_up", pack(4, 2, 3, 6, 0, 1, 0));

    // Paddle saturation at both ends, L+R hold, start ignored mid-play, async reset.
    do_reset("reset_seq_b");
    step(1, 0, 0, 0, 0);
    repeat (20) step(0, 1, 0, 0, 1);
    check("paddle_saturate", pack(7, 5, 0, 6, 0, 0, 0));
    repeat (6)  step(1, 1, 1, 1, 1);
    check("paddle_both_hold", pack(6, 4, 0, 6, 0, 0, 0));
    repeat (2)  step(0, 0, 1, 0, 0);
    check("paddle_right", pack(5, 3, 1, 6, 0, 0, 0));
    do_reset("reset_midplay");

    // Random buttons and occasional start pulses against the model.
    for (int c = 0; c < 4000; c++) begin
      bit [3:0] b;
      b = 4'($urandom);
      step(($urandom % 24) == 0, b[0], b[1], b[2], b[3]);
      check_model("random");
      if (c == 2500) do_reset("reset_random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
